// File: rtl/fa_serial_addsub.sv
// Multi-cycle adder/subtractor: a BPC-bit ripple slice is reused every cycle,
// walking WIDTH-bit operands LSB-first and reporting sum, carry-out and signed overflow.
module fa_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             out_valid,
    output logic             busy
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("fa_serial_addsub: BPC must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_shift;
    logic             carry_reg;
    logic             co_reg;
    logic             ovf_reg;
    logic [CW-1:0]    cnt_reg;
    logic [BPC:0]     chain;
    logic [BPC-1:0]   slice_sum;
    logic             accept;
    logic             last_slice;

    // Ripple slice over the low BPC bits; chain[gi] is the carry into bit gi.
    assign chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_slice
            assign slice_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // Slice results enter from the MSB end so the word is aligned after N steps.
    generate
        if (BPC == WIDTH) begin : g_shift_full
            assign s_shift = slice_sum;
        end else begin : g_shift_part
            assign s_shift = {slice_sum, s_reg[WIDTH-1:BPC]};
        end
    endgenerate

    assign accept     = (state_reg == ST_IDLE) && in_valid;
    assign last_slice = (cnt_reg == CW'(N - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = ST_RUN;
            ST_RUN:  if (last_slice) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else if (accept) begin
            // Subtraction is folded into the operand: A + ~B + ~ci.
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= ci ^ sub;
            cnt_reg   <= '0;
        end else if (state_reg == ST_RUN) begin
            a_reg     <= a_reg >> BPC;
            b_reg     <= b_reg >> BPC;
            s_reg     <= s_shift;
            carry_reg <= chain[BPC];
            cnt_reg   <= cnt_reg + CW'(1);
            if (last_slice) begin
                co_reg  <= chain[BPC];
                ovf_reg <= chain[BPC] ^ chain[BPC-1];
            end
        end
    end

    assign s         = s_reg;
    assign co        = co_reg;
    assign ovf       = ovf_reg;
    assign in_ready  = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);

endmodule

// File: tb/tb_fa_serial_addsub.sv
// Bench for fa_serial_addsub: four instances (8/1, 4/1, 4/2, 4/4) checked against
// a plain-arithmetic model for results, latency, handshake and reset behaviour.
module tb_fa_serial_addsub;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       in_valid_all = '0;
    logic [3:0]       in_ready_all;
    logic [3:0][7:0]  a_all = '0;
    logic [3:0][7:0]  b_all = '0;
    logic [3:0]       ci_all = '0;
    logic [3:0]       sub_all = '0;
    logic [3:0][7:0]  s_all;
    logic [3:0]       co_all;
    logic [3:0]       ovf_all;
    logic [3:0]       out_valid_all;
    logic [3:0]       busy_all;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 8 : 4;
            localparam int B = (gi == 3) ? 4 : ((gi == 2) ? 2 : 1);
            logic [W-1:0] s_w;
            fa_serial_addsub #(.WIDTH(W), .BPC(B)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_all[gi]),
                .in_ready  (in_ready_all[gi]),
                .a         (a_all[gi][W-1:0]),
                .b         (b_all[gi][W-1:0]),
                .ci        (ci_all[gi]),
                .sub       (sub_all[gi]),
                .s         (s_w),
                .co        (co_all[gi]),
                .ovf       (ovf_all[gi]),
                .out_valid (out_valid_all[gi]),
                .busy      (busy_all[gi])
            );
            assign s_all[gi] = 8'(s_w);
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int nsl(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : ((k == 2) ? 2 : 1));
    endfunction

    // Reference: integer add of A, (optionally complemented) B and carry; overflow
    // from the sign rule (equal operand signs, different result sign).
    task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input logic civ, input logic subv,
                         output logic [7:0] es, output logic eco, output logic eovf);
        int unsigned mask, aa, bb, tot, sa, sb, ss;
        mask = (32'd1 << w) - 1;
        aa   = av & mask;
        bb   = subv ? (~{24'd0, bv}) & mask : bv & mask;
        tot  = aa + bb + ((civ ^ subv) ? 1 : 0);
        es   = 8'(tot & mask);
        eco  = tot[w];
        sa   = (aa >> (w - 1)) & 1;
        sb   = (bb >> (w - 1)) & 1;
        ss   = (tot >> (w - 1)) & 1;
        eovf = (sa == sb) && (ss != sa);
    endtask

    task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic civ, input logic subv, input bit garbage);
        logic [7:0] es;
        logic       eco, eovf;
        int         lat;
        bit         got;
        string      id;
        id = $sformatf("k%0d a=%0h b=%0h ci=%0b sub=%0b", k, av, bv, civ, subv);
        model(wid(k), av, bv, civ, subv, es, eco, eovf);
        @(negedge clk);
        chk({id, " ready_idle"}, 32'(in_ready_all[k]), 32'd1);
        a_all[k] = av; b_all[k] = bv; ci_all[k] = civ; sub_all[k] = subv;
        in_valid_all[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_all[k] = 1'b0;
        chk({id, " busy_run"}, 32'(busy_all[k]), 32'd1);
        lat = 0;
        got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (garbage) begin
                in_valid_all[k] = 1'($urandom);
                a_all[k] = 8'($urandom); b_all[k] = 8'($urandom);
                ci_all[k] = 1'($urandom); sub_all[k] = 1'($urandom);
            end
            @(negedge clk);
            chk({id, " ready_low"}, 32'(in_ready_all[k]), 32'd0);
            if (out_valid_all[k]) begin
                got = 1;
                lat = c;
                in_valid_all[k] = 1'b0;
            end
        end
        in_valid_all[k] = 1'b0;
        chk({id, " latency"}, 32'(lat), 32'(nsl(k)));
        chk({id, " s"}, 32'(s_all[k]), 32'(es));
        chk({id, " co"}, 32'(co_all[k]), 32'(eco));
        chk({id, " ovf"}, 32'(ovf_all[k]), 32'(eovf));
        @(negedge clk);
        chk({id, " strobe_width"}, 32'(out_valid_all[k]), 32'd0);
        chk({id, " ready_back"}, 32'(in_ready_all[k]), 32'd1);
        chk({id, " s_hold"}, 32'(s_all[k]), 32'(es));
        $display("[TB] op %s -> s=%0h co=%0b ovf=%0b lat=%0d", id, s_all[k], co_all[k], ovf_all[k], lat);
    endtask

    // Hold in_valid high and check accepts land exactly N+2 cycles apart.
    task automatic b2b(input int k);
        logic [7:0] av, bv, es;
        logic       subv, eco, eovf;
        int         n, acc, prev, len;
        n    = nsl(k);
        av   = 8'($urandom);
        bv   = 8'($urandom);
        subv = 1'($urandom);
        model(wid(k), av, bv, 1'b0, subv, es, eco, eovf);
        len  = 3 * (n + 2);
        acc  = 0;
        prev = -1;
        @(negedge clk);
        a_all[k] = av; b_all[k] = bv; ci_all[k] = 1'b0; sub_all[k] = subv;
        in_valid_all[k] = 1'b1;
        for (int cyc = 0; cyc < len; cyc++) begin
            if (in_ready_all[k] && in_valid_all[k]) begin
                if (prev >= 0)
                    chk($sformatf("k%0d b2b_period", k), 32'(cyc - prev), 32'(n + 2));
                prev = cyc;
                acc++;
            end
            if (out_valid_all[k]) begin
                chk($sformatf("k%0d b2b_s", k), 32'(s_all[k]), 32'(es));
                chk($sformatf("k%0d b2b_co", k), 32'(co_all[k]), 32'(eco));
            end
            @(negedge clk);
        end
        in_valid_all[k] = 1'b0;
        chk($sformatf("k%0d b2b_accepts", k), 32'(acc), 32'd3);
        $display("[TB] b2b k%0d accepts=%0d period_expected=%0d", k, acc, n + 2);
        repeat (n + 3) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d rst_s", k), 32'(s_all[k]), 32'd0);
            chk($sformatf("k%0d rst_co_ovf", k), 32'({co_all[k], ovf_all[k]}), 32'd0);
            chk($sformatf("k%0d rst_valid_busy", k), 32'({out_valid_all[k], busy_all[k]}), 32'd0);
            chk($sformatf("k%0d rst_ready", k), 32'(in_ready_all[k]), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 0);
        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        do_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, 0);
        do_op(0, 8'h10, 8'h20, 1'b0, 1'b1, 1);
        do_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 1);
        for (int i = 0; i < 100; i++)
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1);

        for (int k = 1; k < 4; k++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int m = 0; m < 4; m++)
                        do_op(k, 8'(av), 8'(bv), m[0], m[1], 1'($urandom));

        for (int k = 0; k < 4; k++)
            b2b(k);

        // Asynchronous reset pulse while the 8-bit instance is three slices in.
        @(negedge clk);
        a_all[0] = 8'hFF; b_all[0] = 8'hFF; ci_all[0] = 1'b0; sub_all[0] = 1'b0;
        in_valid_all[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_all[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_s", 32'(s_all[0]), 32'd0);
        chk("rstmid_co_ovf", 32'({co_all[0], ovf_all[0]}), 32'd0);
        chk("rstmid_busy", 32'(busy_all[0]), 32'd0);
        chk("rstmid_ready", 32'(in_ready_all[0]), 32'd1);
        chk("rstmid_valid", 32'(out_valid_all[0]), 32'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rstmid_no_strobe", 32'(out_valid_all[0]), 32'd0);
        end
        $display("[TB] async reset pulse mid-run applied");
        do_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
